core_wb_stage: RTL
==================

Name: core_wb_stage

Overview:
Write-back stage of the 32-bit core. Sits directly upstream of the GPR file and is the only driver of its `wb` / `wb_addr` / `wb_data` write port.
- Retires ALU results from execute.
- Waits for load responses from the data-memory port, formats them (byte/half/word, sign/zero extend) and issues the register write.
- Keeps a retire counter and sticky error flags.

Parameters:
- LOAD_TIMEOUT, 255: max cycles spent in WAIT_LOAD/DRAIN before the load is abandoned; counter width is $clog2(LOAD_TIMEOUT+1).
- CNT_W, 32: width of the retire counter.

Ports:
- clk  in  1  core clock (one clock domain).
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  execute offers an instruction.
- ex_ready  out  1  stage accepts this cycle.
- ex_kind  in  1  0 = ALU result, 1 = load.
- ex_wen  in  1  ALU instruction writes rd.
- ex_rd  in  4  destination register.
- ex_result  in  32  ALU result.
- ex_ld_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- ex_ld_signed  in  1  sign-extend the load.
- ex_ld_off  in  2  byte address bits [1:0].
- mem_rvalid  in  1  load data returned (single-cycle pulse).
- mem_rdata  in  32  raw aligned word.
- flush  in  1  pipeline flush.
- wb  out  1  register write enable.
- wb_addr  out  4  register write address.
- wb_data  out  32  register write data.
- retired_cnt  out  CNT_W  count of retired instructions.
- err_unexp  out  1  sticky: mem_rvalid seen in IDLE.
- err_timeout  out  1  sticky: load abandoned by timeout.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; wb=0, wb_addr=0, wb_data=0.
  - retired_cnt=0, err_unexp=0, err_timeout=0, timeout counter=0.
  - Reset mid-load drops the load; no write is issued.
- All outputs are registered except ex_ready, which is combinational: ex_ready = (state==IDLE) & ~flush.
- Accept condition: ex_valid & ex_ready.
- wb is a single-cycle pulse. When no write occurs, wb=0 and wb_addr/wb_data hold their previous values.
- IDLE:
  - Accept ALU with ex_wen=1: next cycle wb=1, wb_addr=ex_rd, wb_data=ex_result; retired_cnt+1. Latency is 1 cycle.
  - Accept ALU with ex_wen=0: no write; retired_cnt+1 next cycle.
  - Accept load: latch rd, size, signed, off; clear the timeout counter; go to WAIT_LOAD.
  - mem_rvalid in IDLE: data ignored; err_unexp set.
- WAIT_LOAD:
  - mem_rvalid=1: next cycle wb=1, wb_addr=latched rd, wb_data=formatted data; retired_cnt+1; go to IDLE.
  - The earliest write for a load is therefore 1 cycle after the response. A response in the same cycle as load accept is ignored (state is still IDLE) and flagged as err_unexp.
- Load formatting:
  - byte: lane = off; bits [8*off+7 : 8*off].
  - half: lane = off[1]; off[0] is ignored.
  - word and reserved size: full 32 bits.
  - Extension: sign-extend if signed=1, else zero-extend.
- Flush:
  - flush in WAIT_LOAD with mem_rvalid=0: go to DRAIN.
  - flush and mem_rvalid in the same cycle: flush wins; data discarded; no write; go to IDLE.
  - flush in IDLE: blocks acceptance only.
- DRAIN:
  - mem_rvalid: discard the data; go to IDLE.
  - flush has no further effect in DRAIN.
- Timeout:
  - The counter increments each cycle in WAIT_LOAD/DRAIN.
  - When it reaches LOAD_TIMEOUT: no write, err_timeout=1, go to IDLE.
  - mem_rvalid in the expiry cycle takes precedence over timeout.
- retired_cnt wraps modulo 2^CNT_W. Flushed and timed-out loads do not count.

Optional Feature:
CORE_WB_BYPASS_EN
- Defined: adds outputs byp_valid (1), byp_addr (4) and byp_data (32), equal to wb, wb_addr and wb_data. These give decode a forwarding source for the cycle in which the GPR write is not yet readable.
- Undefined: the ports are absent; no added logic.

Decomposition:
- Package core_wb_pkg holds:
  - typedef enum ld_size_t {LD_B, LD_H, LD_W, LD_RSV}.
  - typedef enum wb_state_t {WB_IDLE, WB_WAIT_LOAD, WB_DRAIN}.
  - localparams EX_KIND_ALU=0, EX_KIND_LD=1.
- One combinational sub-module, core_wb_ldfmt (inputs: raw word, size, signed, off; output: 32-bit data), reusable by a future store/load unit.

Test Plan:
1. ALU: ex_kind=0, ex_wen=1, rd=3, result=32'hDEADBEEF -> next cycle wb=1, wb_addr=3, wb_data=32'hDEADBEEF; retired_cnt=1; following cycle wb=0.
2. Signed byte load: rd=5, off=2, signed=1, mem_rdata=32'h0080_0000 arriving 4 cycles after accept -> ex_ready=0 while waiting; wb_data=32'hFFFF_FF80, wb_addr=5 one cycle after mem_rvalid.
3. Unsigned half load: off=3, signed=0, mem_rdata=32'h8001_1234 -> wb_data=32'h0000_8001.
4. flush 2 cycles after load accept, mem_rvalid 3 cycles later -> no wb pulse, retired_cnt unchanged, ex_ready returns to 1 the cycle after the response.
5. LOAD_TIMEOUT=8, no response -> err_timeout=1 at cycle 8; state IDLE; a later mem_rvalid sets err_unexp.
6. rst_n=0 during WAIT_LOAD, then mem_rvalid -> all outputs 0, no write, err_unexp=1.

Source files
------------

// File: rtl/core_wb_pkg.sv
// Shared types for the core write-back stage: load size codes, FSM states and
// the load context captured when a load is accepted from execute.
package core_wb_pkg;

    typedef enum logic [1:0] {
        LD_B   = 2'b00,
        LD_H   = 2'b01,
        LD_W   = 2'b10,
        LD_RSV = 2'b11
    } ld_size_t;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_WAIT_LOAD = 2'd1,
        WB_DRAIN     = 2'd2
    } wb_state_t;

    localparam logic EX_KIND_ALU = 1'b0;
    localparam logic EX_KIND_LD  = 1'b1;

    typedef struct packed {
        logic [3:0] rd;
        ld_size_t   size;
        logic       sgn;
        logic [1:0] off;
    } ld_ctx_t;

endpackage

// File: rtl/core_wb_stage_if.sv
// Execute-side offer, data-memory response and GPR write port of the
// write-back stage. The stage connects through the slave modport.
interface core_wb_stage_if;
    import core_wb_pkg::*;

    logic        ex_valid;
    logic        ex_ready;
    logic        ex_kind;
    logic        ex_wen;
    logic [3:0]  ex_rd;
    logic [31:0] ex_result;
    ld_size_t    ex_ld_size;
    logic        ex_ld_signed;
    logic [1:0]  ex_ld_off;

    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output ex_valid, ex_kind, ex_wen, ex_rd, ex_result,
               ex_ld_size, ex_ld_signed, ex_ld_off,
               mem_rvalid, mem_rdata,
        input  ex_ready, wb, wb_addr, wb_data
    );

    modport slave (
        input  ex_valid, ex_kind, ex_wen, ex_rd, ex_result,
               ex_ld_size, ex_ld_signed, ex_ld_off,
               mem_rvalid, mem_rdata,
        output ex_ready, wb, wb_addr, wb_data
    );

endinterface

// File: rtl/core_wb_ldfmt.sv
// Load data formatter: selects the byte/half lane of an aligned word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module core_wb_ldfmt
    import core_wb_pkg::*;
(
    input  logic [31:0] raw,
    input  ld_size_t    size,
    input  logic        sgn,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        byte_lane = raw[7:0];
        case (off)
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            2'd3:    byte_lane = raw[31:24];
            default: byte_lane = raw[7:0];
        endcase

        // Half lane ignores off[0]; misaligned halves read the containing half.
        half_lane = off[1] ? raw[31:16] : raw[15:0];

        data = raw;
        case (size)
            LD_B:    data = {{24{sgn & byte_lane[7]}}, byte_lane};
            LD_H:    data = {{16{sgn & half_lane[15]}}, half_lane};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/core_wb_stage.sv
// Write-back stage: retires ALU results, waits for and formats load data, and
// drives the GPR write port. Optional forwarding outputs: CORE_WB_BYPASS_EN.
module core_wb_stage
    import core_wb_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    core_wb_stage_if.slave   bus,
    input  logic             flush,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             err_unexp,
    output logic             err_timeout
`ifdef CORE_WB_BYPASS_EN
    ,
    output logic             byp_valid,
    output logic [3:0]       byp_addr,
    output logic [31:0]      byp_data
`endif
);

    localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);

    wb_state_t        state, state_n;
    ld_ctx_t          ld_q, ld_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic             wb_q, wb_n;
    logic [3:0]       wb_addr_q, wb_addr_n;
    logic [31:0]      wb_data_q, wb_data_n;
    logic [CNT_W-1:0] cnt_n;
    logic             unexp_n, tmo_err_n;
    logic             accept;
    logic [31:0]      ld_data;

    core_wb_ldfmt u_ldfmt (
        .raw  (bus.mem_rdata),
        .size (ld_q.size),
        .sgn  (ld_q.sgn),
        .off  (ld_q.off),
        .data (ld_data)
    );

    assign bus.ex_ready = (state == WB_IDLE) & ~flush;
    assign accept       = bus.ex_valid & bus.ex_ready;

    always_comb begin
        state_n   = state;
        ld_n      = ld_q;
        tmo_n     = tmo_cnt;
        wb_n      = 1'b0;
        wb_addr_n = wb_addr_q;
        wb_data_n = wb_data_q;
        cnt_n     = retired_cnt;
        unexp_n   = err_unexp;
        tmo_err_n = err_timeout;

        case (state)
            WB_IDLE: begin
                if (bus.mem_rvalid) unexp_n = 1'b1;
                if (accept) begin
                    if (bus.ex_kind == EX_KIND_ALU) begin
                        cnt_n = retired_cnt + CNT_W'(1);
                        if (bus.ex_wen) begin
                            wb_n      = 1'b1;
                            wb_addr_n = bus.ex_rd;
                            wb_data_n = bus.ex_result;
                        end
                    end else begin
                        ld_n    = '{rd: bus.ex_rd, size: bus.ex_ld_size,
                                    sgn: bus.ex_ld_signed, off: bus.ex_ld_off};
                        tmo_n   = '0;
                        state_n = WB_WAIT_LOAD;
                    end
                end
            end

            WB_WAIT_LOAD: begin
                tmo_n = tmo_cnt + TMO_W'(1);
                // Response beats timeout; a flush in the same cycle discards it.
                if (bus.mem_rvalid) begin
                    state_n = WB_IDLE;
                    if (!flush) begin
                        wb_n      = 1'b1;
                        wb_addr_n = ld_q.rd;
                        wb_data_n = ld_data;
                        cnt_n     = retired_cnt + CNT_W'(1);
                    end
                end else if (tmo_n == TMO_W'(LOAD_TIMEOUT)) begin
                    tmo_err_n = 1'b1;
                    state_n   = WB_IDLE;
                end else if (flush) begin
                    state_n = WB_DRAIN;
                end
            end

            WB_DRAIN: begin
                tmo_n = tmo_cnt + TMO_W'(1);
                if (bus.mem_rvalid) begin
                    state_n = WB_IDLE;
                end else if (tmo_n == TMO_W'(LOAD_TIMEOUT)) begin
                    tmo_err_n = 1'b1;
                    state_n   = WB_IDLE;
                end
            end

            default: state_n = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= WB_IDLE;
            tmo_cnt     <= '0;
            wb_q        <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            retired_cnt <= '0;
            err_unexp   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            tmo_cnt     <= tmo_n;
            wb_q        <= wb_n;
            wb_addr_q   <= wb_addr_n;
            wb_data_q   <= wb_data_n;
            retired_cnt <= cnt_n;
            err_unexp   <= unexp_n;
            err_timeout <= tmo_err_n;
        end
    end

    // NOTE: the load context has no reset; it is only read in WAIT_LOAD, after an accept has written it.
    always_ff @(posedge clk) begin
        ld_q <= ld_n;
    end

    assign bus.wb      = wb_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

`ifdef CORE_WB_BYPASS_EN
    assign byp_valid = wb_q;
    assign byp_addr  = wb_addr_q;
    assign byp_data  = wb_data_q;
`endif

endmodule
